// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, FSM encoding, shift schedule,
// the PC-2 selection table and the 28-bit half rotators.
package des_pkg;

    localparam int HALF_W  = 28;
    localparam int KEY_W   = 48;
    localparam int ROUND_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Entry [i] is the rotate amount s[i+1] applied to reach round i+1.
    localparam logic [1:0] SHIFT_TABLE [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Entry [i] is the FIPS {C,D} bit number (1 = MSB of C) that feeds subkey bit i+1.
    localparam logic [5:0] PC2_TABLE [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] x,
                                                    input logic [1:0] amt);
        case (amt)
            2'd1:    rotl_half = {x[26:0], x[27]};
            2'd2:    rotl_half = {x[25:0], x[27:26]};
            default: rotl_half = x;
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] x,
                                                    input logic [1:0] amt);
        case (amt)
            2'd1:    rotr_half = {x[0], x[27:1]};
            2'd2:    rotr_half = {x[1:0], x[27:2]};
            default: rotr_half = x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2: selects the 48 subkey bits from the 56-bit {C,D} pair.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*HALF_W:1] cd,
    output logic [KEY_W:1]    subkey
);

    for (genvar i = 0; i < KEY_W; i++) begin : g_sel
        assign subkey[KEY_W - i] = cd[2*HALF_W + 1 - int'(PC2_TABLE[i])];
    end

endmodule

// File: rtl/des_round_key_schedule.sv
// DES round-key generator streaming K1..K16 (or K16..K1) with a valid/ready handshake.
// Decrypt ordering is built only when DES_KEY_SCHED_DECRYPT_EN is defined.
module des_round_key_schedule
    import des_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               DECRYPT,
    input  logic [HALF_W:1]    C_IN,
    input  logic [HALF_W:1]    D_IN,
    input  logic               SUBKEY_READY,
    output logic               SUBKEY_VALID,
    output logic [KEY_W:1]     SUBKEY,
    output logic [ROUND_W-1:0] ROUND,
    output logic               BUSY,
    output logic               DONE
);

    state_t               state_r;
    state_t               state_next_s;
    logic [HALF_W:1]      c_r;
    logic [HALF_W:1]      d_r;
    logic [HALF_W:1]      c_step_s;
    logic [HALF_W:1]      d_step_s;
    logic [ROUND_W-1:0]   round_r;
    logic [ROUND_W-1:0]   round_step_s;
    logic                 dec_s;
    logic                 dec_r;
    logic                 hs_s;
    logic                 last_s;
    logic                 load_s;

`ifdef DES_KEY_SCHED_DECRYPT_EN
    assign dec_s = DECRYPT;
`else
    logic unused_decrypt_s;
    assign unused_decrypt_s = DECRYPT;
    assign dec_s            = 1'b0;
`endif

    assign load_s = (state_r == ST_IDLE) && START;
    assign hs_s   = (state_r == ST_RUN) && SUBKEY_READY;
    assign last_s = dec_r ? (round_r == 4'd0) : (round_r == 4'd15);

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (hs_s && last_s) state_next_s = ST_FINISH;
                else                state_next_s = ST_RUN;
            end
            ST_FINISH: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        SUBKEY_VALID = 1'b0;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                SUBKEY_VALID = 1'b0;
            end
            ST_RUN: begin
                SUBKEY_VALID = 1'b1;
                BUSY         = 1'b1;
            end
            ST_FINISH: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: begin
                SUBKEY_VALID = 1'b0;
            end
        endcase
    end

`ifdef DES_KEY_SCHED_DECRYPT_EN
    // Next-round halves: forward rotates for encrypt, backward rotates for decrypt
    always_comb begin
        if (dec_r) begin
            c_step_s     = rotr_half(c_r, SHIFT_TABLE[round_r]);
            d_step_s     = rotr_half(d_r, SHIFT_TABLE[round_r]);
            round_step_s = round_r - 4'd1;
        end else begin
            c_step_s     = rotl_half(c_r, SHIFT_TABLE[round_r + 4'd1]);
            d_step_s     = rotl_half(d_r, SHIFT_TABLE[round_r + 4'd1]);
            round_step_s = round_r + 4'd1;
        end
    end
`else
    // Next-round halves, encrypt direction only
    always_comb begin
        c_step_s     = rotl_half(c_r, SHIFT_TABLE[round_r + 4'd1]);
        d_step_s     = rotl_half(d_r, SHIFT_TABLE[round_r + 4'd1]);
        round_step_s = round_r + 4'd1;
    end
`endif

    // C/D halves, round index and direction; held whenever no handshake occurs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            c_r     <= 28'd0;
            d_r     <= 28'd0;
            round_r <= 4'd0;
            dec_r   <= 1'b0;
        end else if (load_s) begin
            dec_r <= dec_s;
            // Decrypt starts at K16, whose cumulative rotation of 28 restores C0/D0
            if (dec_s) begin
                c_r     <= C_IN;
                d_r     <= D_IN;
                round_r <= 4'd15;
            end else begin
                c_r     <= rotl_half(C_IN, 2'd1);
                d_r     <= rotl_half(D_IN, 2'd1);
                round_r <= 4'd0;
            end
        end else if (hs_s && !last_s) begin
            c_r     <= c_step_s;
            d_r     <= d_step_s;
            round_r <= round_step_s;
        end else begin
            c_r     <= c_r;
            d_r     <= d_r;
            round_r <= round_r;
        end
    end

    assign ROUND = round_r;

    des_pc2 u_pc2 (
        .cd     ({c_r, d_r}),
        .subkey (SUBKEY)
    );

endmodule
